pipeline_exec_ctrl: RTL and testbench
=====================================

// Module: pipeline_exec_ctrl
// PURPOSE
//  Sequences the 5-stage MIPS pipeline: run, single-step, halt, drain and register dump.
//  Generates global stage enable, PC enable, ID stall and IF flush from load-use hazard and jump inputs.
//  After a halt it drains in-flight instructions, then walks the register-file read address for the debug dump.
//  Sits between the debug/UART command path and the IF/ID/EX/MEM/WB stage registers.
// PARAMETERS
//  NB_ADDR      5   register-file address width
//  NUM_REGS     32  registers walked in DUMP (addresses 0..NUM_REGS-1)
//  DRAIN_CYCLES 4   bubble cycles needed to retire in-flight instructions after halt
//  NB_CNT       32  cycle counter width
// PORTS
//  clk               in   1        clock
//  i_rst             in   1        synchronous reset, active-high
//  i_cmd_valid       in   1        command strobe
//  i_cmd             in   2        01 RUN, 10 STEP, 11 HALT, 00 ignored (accepted, no effect)
//  o_cmd_ready       out  1        command accepted when valid && ready
//  i_halt_instr      in   1        HALT opcode reached WB
//  i_load_use_hazard in   1        ID instruction depends on EX load
//  i_jump_taken      in   1        ID resolved taken jump/branch (o_jump of decode)
//  o_pipe_en         out  1        global enable for all stage registers
//  o_pc_en           out  1        PC register update enable
//  o_stall           out  1        drives ID i_stall
//  o_flush_if        out  1        replace IF/ID contents with NOP
//  o_dump_valid      out  1        o_dump_addr valid
//  i_dump_ready      in   1        consumer took current dump address
//  o_dump_addr       out  NB_ADDR  register-file read address during DUMP
//  o_halted          out  1        high in HALTED
//  o_state           out  3        current state encoding
//  o_cycle_count     out  NB_CNT   count of cycles with o_pipe_en=1
// BEHAVIOUR
//  States: IDLE=0 RUN=1 STEP=2 DRAIN=3 DUMP=4 HALTED=5; state, counters and halt_src are registered.
//  Reset: state IDLE, drain cnt 0, o_dump_addr 0, o_cycle_count 0, halt_src 0; all outputs 0 except o_cmd_ready=1.
//  o_cmd_ready=1 in IDLE and RUN only. Commands offered in other states are not accepted.
//  IDLE: RUN -> RUN; STEP -> STEP; HALT and 00 are consumed without effect. Pipe frozen (all enables 0).
//  RUN: o_pipe_en=1; o_pc_en=!hazard; o_stall=hazard; o_flush_if=jump && !hazard (stall wins).
//   i_halt_instr -> DRAIN with halt_src=1. Accepted HALT -> DRAIN with halt_src=0.
//   Both in the same cycle -> DRAIN with halt_src=1. RUN/STEP received in RUN are consumed, no effect.
//  STEP: exactly one cycle with RUN output equations, then -> IDLE.
//   If i_halt_instr is seen in that cycle -> DRAIN with halt_src=1.
//  DRAIN: o_pipe_en=1, o_pc_en=0, o_flush_if=1, o_stall=0.
//   Drain cnt counts 0..DRAIN_CYCLES-1; on the last value -> DUMP with o_dump_addr=0.
//  DUMP: o_dump_valid=1, o_pipe_en=0. On valid&&ready, o_dump_addr increments next cycle.
//   Transfer at addr NUM_REGS-1 -> HALTED if halt_src else IDLE; addr returns to 0 and never wraps mid-dump.
//   i_dump_ready low holds addr and valid stable.
//  HALTED: all enables 0, o_halted=1. Only i_rst exits.
//  Control outputs (enables, stall, flush, dump_valid) are combinational from state and inputs: zero latency.
//  Reset asserted in any state (including mid-DRAIN/DUMP) -> IDLE next edge; o_dump_valid=0 that cycle.
//  Cycle counter (+1 when o_pipe_en=1) saturates at all-ones; no wrap.
// CONFIGURATION
//  PIPE_CTRL_CYCLE_CNT_EN defined: o_cycle_count implemented as above.
//  PIPE_CTRL_CYCLE_CNT_EN undefined: no counter flops; o_cycle_count tied to 0.
// TESTING
//  1 Reset, cmd RUN, 10 clean cycles -> o_pipe_en=o_pc_en=1 each cycle; o_cycle_count=10.
//  2 RUN, hazard=1 and jump=1 same cycle -> o_stall=1, o_pc_en=0, o_flush_if=0; next cycle jump only -> o_flush_if=1.
//  3 IDLE, STEP x3 -> exactly 3 cycles of o_pipe_en=1, state back to IDLE after each; o_cycle_count=3.
//  4 RUN, i_halt_instr -> 4 DRAIN cycles with pc_en=0, then dump addr 0..31;
//    ready stuck low 5 cycles at addr 7 holds addr 7; after addr 31 -> HALTED, o_halted=1; further cmds not accepted.
//  5 RUN, HALT cmd -> DRAIN, DUMP, then IDLE. Reset at dump addr 12 -> IDLE, addr 0, valid 0.
//  6 Force o_cycle_count to all-ones -> stays all-ones. With macro undefined -> o_cycle_count=0 throughout.

Source files
------------

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the 5-stage pipeline: run / single-step / halt, drain, register dump.
// Optional cycle counter is built only when PIPE_CTRL_CYCLE_CNT_EN is defined; otherwise o_cycle_count is 0.
module pipeline_exec_ctrl #(
    parameter int NB_ADDR      = 5,
    parameter int NUM_REGS     = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CNT       = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_halt_instr,
    input  logic               i_load_use_hazard,
    input  logic               i_jump_taken,
    output logic               o_pipe_en,
    output logic               o_pc_en,
    output logic               o_stall,
    output logic               o_flush_if,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic               o_halted,
    output logic [2:0]         o_state,
    output logic [NB_CNT-1:0]  o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DUMP   = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_t;

    localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);
    localparam logic [NB_ADDR-1:0]  ADDR_LAST  = NB_ADDR'(NUM_REGS - 1);

    state_t              state, state_nxt;
    logic                halt_src, halt_src_nxt;
    logic [NB_DRAIN-1:0] drain_cnt, drain_cnt_nxt;
    logic [NB_ADDR-1:0]  dump_addr, dump_addr_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            halt_src  <= 1'b0;
            drain_cnt <= '0;
            dump_addr <= '0;
        end else begin
            state     <= state_nxt;
            halt_src  <= halt_src_nxt;
            drain_cnt <= drain_cnt_nxt;
            dump_addr <= dump_addr_nxt;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_nxt     = state;
        halt_src_nxt  = halt_src;
        drain_cnt_nxt = drain_cnt;
        dump_addr_nxt = dump_addr;
        o_cmd_ready   = 1'b0;
        o_pipe_en     = 1'b0;
        o_pc_en       = 1'b0;
        o_stall       = 1'b0;
        o_flush_if    = 1'b0;
        o_dump_valid  = 1'b0;
        o_halted      = 1'b0;

        case (state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    if (i_cmd == CMD_RUN)  state_nxt = ST_RUN;
                    if (i_cmd == CMD_STEP) state_nxt = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                o_cmd_ready = (state == ST_RUN);
                o_pipe_en   = 1'b1;
                o_pc_en     = !i_load_use_hazard;
                o_stall     = i_load_use_hazard;
                o_flush_if  = i_jump_taken && !i_load_use_hazard;  // stall wins over flush
                // A HALT reaching WB takes priority over a HALT command in the same cycle.
                if (i_halt_instr) begin
                    state_nxt     = ST_DRAIN;
                    halt_src_nxt  = 1'b1;
                    drain_cnt_nxt = '0;
                end else if (state == ST_RUN && i_cmd_valid && i_cmd == CMD_HALT) begin
                    state_nxt     = ST_DRAIN;
                    halt_src_nxt  = 1'b0;
                    drain_cnt_nxt = '0;
                end else if (state == ST_STEP) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                o_pipe_en  = 1'b1;
                o_flush_if = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = ST_DUMP;
                    drain_cnt_nxt = '0;
                    dump_addr_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + NB_DRAIN'(1);
                end
            end
            ST_DUMP: begin
                o_dump_valid = 1'b1;
                if (i_dump_ready) begin
                    if (dump_addr == ADDR_LAST) begin
                        dump_addr_nxt = '0;
                        state_nxt     = halt_src ? ST_HALTED : ST_IDLE;
                    end else begin
                        dump_addr_nxt = dump_addr + NB_ADDR'(1);
                    end
                end
            end
            ST_HALTED: o_halted = 1'b1;
            default:   state_nxt = ST_IDLE;
        endcase

        // Reset forces the reset-state output view in the same cycle.
        if (i_rst) begin
            o_cmd_ready  = 1'b1;
            o_pipe_en    = 1'b0;
            o_pc_en      = 1'b0;
            o_stall      = 1'b0;
            o_flush_if   = 1'b0;
            o_dump_valid = 1'b0;
            o_halted     = 1'b0;
        end
    end

    assign o_dump_addr = dump_addr;
    assign o_state     = state;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    logic [NB_CNT-1:0] cycle_cnt;

    // Saturating count of enabled pipeline cycles.
    always_ff @(posedge clk) begin
        if (i_rst)
            cycle_cnt <= '0;
        else if (o_pipe_en && cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + NB_CNT'(1);
    end

    assign o_cycle_count = cycle_cnt;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed self-checking bench for pipeline_exec_ctrl; a second narrow-counter instance exercises saturation.
module tb_pipeline_exec_ctrl;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic        i_halt_instr = 1'b0;
    logic        i_load_use_hazard = 1'b0;
    logic        i_jump_taken = 1'b0;
    logic        i_dump_ready = 1'b1;
    logic        o_cmd_ready, o_pipe_en, o_pc_en, o_stall, o_flush_if;
    logic        o_dump_valid, o_halted;
    logic [4:0]  o_dump_addr;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    // Narrow-counter instance for saturation
    logic        s_rst = 1'b1;
    logic        s_cmd_valid = 1'b0;
    logic [1:0]  s_cmd = 2'b00;
    logic        s_zero = 1'b0;
    logic        s_cmd_ready, s_pipe_en, s_pc_en, s_stall, s_flush_if, s_dump_valid, s_halted;
    logic [4:0]  s_dump_addr;
    logic [2:0]  s_state;
    logic [3:0]  s_cycle_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_exec_ctrl u_dut (
        .clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready), .i_halt_instr(i_halt_instr),
        .i_load_use_hazard(i_load_use_hazard), .i_jump_taken(i_jump_taken),
        .o_pipe_en(o_pipe_en), .o_pc_en(o_pc_en), .o_stall(o_stall), .o_flush_if(o_flush_if),
        .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready), .o_dump_addr(o_dump_addr),
        .o_halted(o_halted), .o_state(o_state), .o_cycle_count(o_cycle_count)
    );

    pipeline_exec_ctrl #(.NB_CNT(4)) u_sat (
        .clk(clk), .i_rst(s_rst), .i_cmd_valid(s_cmd_valid), .i_cmd(s_cmd),
        .o_cmd_ready(s_cmd_ready), .i_halt_instr(s_zero),
        .i_load_use_hazard(s_zero), .i_jump_taken(s_zero),
        .o_pipe_en(s_pipe_en), .o_pc_en(s_pc_en), .o_stall(s_stall), .o_flush_if(s_flush_if),
        .o_dump_valid(s_dump_valid), .i_dump_ready(s_zero), .o_dump_addr(s_dump_addr),
        .o_halted(s_halted), .o_state(s_state), .o_cycle_count(s_cycle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 2'b00; i_halt_instr = 1'b0;
        i_load_use_hazard = 1'b0; i_jump_taken = 1'b0; i_dump_ready = 1'b1;
        tick(); tick();
        i_rst = 1'b0;
    endtask

    task automatic send_run();
        i_cmd_valid = 1'b1; i_cmd = 2'b01;
        tick();
        i_cmd_valid = 1'b0; i_cmd = 2'b00;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({o_state, o_cmd_ready, o_pipe_en, o_pc_en, o_stall, o_flush_if, o_dump_valid, o_halted}
            !== {3'd0, 1'b1, 6'b0}) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d ready=%b pipe=%b pc=%b stall=%b flush=%b dv=%b halted=%b",
                     o_state, o_cmd_ready, o_pipe_en, o_pc_en, o_stall, o_flush_if, o_dump_valid, o_halted);
        end
        checks++;
        if (o_dump_addr !== 5'd0 || o_cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: addr=%0d count=%0d expected 0/0", o_dump_addr, o_cycle_count);
        end
    endtask

    task automatic test_run();
        logic [31:0] exp_cnt;
        apply_reset();
        i_cmd_valid = 1'b1; i_cmd = 2'b01;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_pipe_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_run_cmd: ready=%b pipe=%b expected 1/0", o_cmd_ready, o_pipe_en);
        end
        tick();
        i_cmd_valid = 1'b0; i_cmd = 2'b00;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (o_state !== 3'd1 || o_pipe_en !== 1'b1 || o_pc_en !== 1'b1) begin
                errors++;
                $display("FAIL run_cycle%0d: state=%0d pipe=%b pc=%b expected 1/1/1", i, o_state, o_pipe_en, o_pc_en);
            end
            tick();
        end
        exp_cnt = CNT_EN ? 32'd10 : 32'd0;
        checks++;
        if (o_cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL run_count: got %0d expected %0d", o_cycle_count, exp_cnt);
        end
    endtask

    task automatic test_hazard_jump();
        // Continues in RUN from test_run
        i_load_use_hazard = 1'b1; i_jump_taken = 1'b1;
        #1;
        checks++;
        if ({o_pipe_en, o_stall, o_pc_en, o_flush_if} !== 4'b1100) begin
            errors++;
            $display("FAIL hazard_and_jump: pipe/stall/pc/flush=%b expected 1100",
                     {o_pipe_en, o_stall, o_pc_en, o_flush_if});
        end
        tick();
        i_load_use_hazard = 1'b0;
        #1;
        checks++;
        if ({o_pipe_en, o_stall, o_pc_en, o_flush_if} !== 4'b1011) begin
            errors++;
            $display("FAIL jump_only: pipe/stall/pc/flush=%b expected 1011",
                     {o_pipe_en, o_stall, o_pc_en, o_flush_if});
        end
        tick();
        i_jump_taken = 1'b0;
        i_cmd_valid = 1'b1; i_cmd = 2'b10;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_step_consumed_ready: got %b expected 1", o_cmd_ready);
        end
        tick();
        i_cmd_valid = 1'b0;
        checks++;
        if (o_state !== 3'd1) begin
            errors++;
            $display("FAIL run_step_no_effect: state=%0d expected 1", o_state);
        end
    endtask

    task automatic test_step();
        logic [31:0] exp_cnt;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            i_cmd_valid = 1'b1; i_cmd = 2'b10;
            #1;
            checks++;
            if (o_pipe_en !== 1'b0 || o_state !== 3'd0) begin
                errors++;
                $display("FAIL step%0d_idle: state=%0d pipe=%b expected 0/0", i, o_state, o_pipe_en);
            end
            tick();
            i_cmd_valid = 1'b0; i_cmd = 2'b00;
            #1;
            checks++;
            if (o_state !== 3'd2 || o_pipe_en !== 1'b1 || o_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL step%0d_active: state=%0d pipe=%b ready=%b expected 2/1/0",
                         i, o_state, o_pipe_en, o_cmd_ready);
            end
            tick();
            checks++;
            if (o_state !== 3'd0 || o_pipe_en !== 1'b0) begin
                errors++;
                $display("FAIL step%0d_return: state=%0d pipe=%b expected 0/0", i, o_state, o_pipe_en);
            end
        end
        exp_cnt = CNT_EN ? 32'd3 : 32'd0;
        checks++;
        if (o_cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL step_count: got %0d expected %0d", o_cycle_count, exp_cnt);
        end
    endtask

    task automatic check_drain(input string tag);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o_state !== 3'd3 || {o_pipe_en, o_pc_en, o_flush_if, o_stall, o_cmd_ready} !== 5'b10100) begin
                errors++;
                $display("FAIL %s_drain%0d: state=%0d pipe/pc/flush/stall/ready=%b expected 3/10100",
                         tag, i, o_state, {o_pipe_en, o_pc_en, o_flush_if, o_stall, o_cmd_ready});
            end
            tick();
        end
    endtask

    task automatic test_halt_instr_dump();
        apply_reset();
        send_run();
        i_halt_instr = 1'b1;
        tick();
        i_halt_instr = 1'b0;
        check_drain("hinstr");
        for (int a = 0; a < 32; a++) begin
            if (a == 7) begin
                i_dump_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    checks++;
                    if (o_dump_addr !== 5'd7 || o_dump_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL dump_hold%0d: addr=%0d valid=%b expected 7/1", h, o_dump_addr, o_dump_valid);
                    end
                end
                i_dump_ready = 1'b1;
            end
            #1;
            checks++;
            if (o_state !== 3'd4 || o_dump_valid !== 1'b1 || o_pipe_en !== 1'b0 || o_dump_addr !== a[4:0]) begin
                errors++;
                $display("FAIL dump_addr%0d: state=%0d valid=%b pipe=%b addr=%0d expected 4/1/0/%0d",
                         a, o_state, o_dump_valid, o_pipe_en, o_dump_addr, a);
            end
            tick();
        end
        checks++;
        if (o_state !== 3'd5 || o_halted !== 1'b1 || o_dump_valid !== 1'b0 || o_dump_addr !== 5'd0) begin
            errors++;
            $display("FAIL halted_entry: state=%0d halted=%b valid=%b addr=%0d expected 5/1/0/0",
                     o_state, o_halted, o_dump_valid, o_dump_addr);
        end
        i_cmd_valid = 1'b1; i_cmd = 2'b01;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0 || o_pipe_en !== 1'b0) begin
            errors++;
            $display("FAIL halted_cmd: ready=%b pipe=%b expected 0/0", o_cmd_ready, o_pipe_en);
        end
        tick(); tick();
        i_cmd_valid = 1'b0;
        checks++;
        if (o_state !== 3'd5 || o_halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_sticky: state=%0d halted=%b expected 5/1", o_state, o_halted);
        end
    endtask

    task automatic enter_dump_by_cmd(input string tag);
        send_run();
        i_cmd_valid = 1'b1; i_cmd = 2'b11;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt_ready: got %b expected 1", tag, o_cmd_ready);
        end
        tick();
        i_cmd_valid = 1'b0; i_cmd = 2'b00;
        check_drain(tag);
    endtask

    task automatic test_halt_cmd_and_reset();
        apply_reset();
        enter_dump_by_cmd("hcmd");
        repeat (32) tick();
        checks++;
        if (o_state !== 3'd0 || o_halted !== 1'b0 || o_dump_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL hcmd_return_idle: state=%0d halted=%b valid=%b ready=%b expected 0/0/0/1",
                     o_state, o_halted, o_dump_valid, o_cmd_ready);
        end
        enter_dump_by_cmd("rst");
        repeat (12) tick();
        checks++;
        if (o_dump_addr !== 5'd12 || o_dump_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_addr: addr=%0d valid=%b expected 12/1", o_dump_addr, o_dump_valid);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_same_cycle: got %b expected 0", o_dump_valid);
        end
        tick();
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_state !== 3'd0 || o_dump_addr !== 5'd0 || o_dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_dump: state=%0d addr=%0d valid=%b expected 0/0/0",
                     o_state, o_dump_addr, o_dump_valid);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_sat;
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        s_cmd_valid = 1'b1; s_cmd = 2'b01;
        tick();
        s_cmd_valid = 1'b0;
        repeat (20) tick();
        exp_sat = CNT_EN ? 4'hF : 4'h0;
        checks++;
        if (s_cycle_count !== exp_sat || s_pipe_en !== 1'b1) begin
            errors++;
            $display("FAIL sat_reach: count=%0d pipe=%b expected %0d/1", s_cycle_count, s_pipe_en, exp_sat);
        end
        repeat (3) tick();
        checks++;
        if (s_cycle_count !== exp_sat) begin
            errors++;
            $display("FAIL sat_hold: count=%0d expected %0d", s_cycle_count, exp_sat);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_hazard_jump();
        test_step();
        test_halt_instr_dump();
        test_halt_cmd_and_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
